// File: rtl/id_stage_rim.sv
// id_stage_rim: registered decode stage between IF and EX.
// Decodes R-type / I-type ALU instructions, reads the regfile combinationally,
// forwards EX/MEM results, stalls on load-use hazards and hands a registered
// payload to EX over a valid/ready handshake. Keeps a saturating count of
// hazard stall cycles.
// Optional feature: define ID_MULDIV_EN to accept M-extension encodings
// (opcode 0110011, funct7 0000001); otherwise they decode as illegal.
module id_stage_rim #(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ILEN-1:0]    inst_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic [RADDR_W-1:0] reg2_raddr_o,
    output logic               reg1_re_o,
    output logic               reg2_re_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic [XLEN-1:0]    reg2_rdata_i,
    input  logic               ex_fwd_we_i,
    input  logic [RADDR_W-1:0] ex_fwd_waddr_i,
    input  logic [XLEN-1:0]    ex_fwd_data_i,
    input  logic               mem_fwd_we_i,
    input  logic [RADDR_W-1:0] mem_fwd_waddr_i,
    input  logic [XLEN-1:0]    mem_fwd_data_i,
    input  logic               ex_is_load_i,
    input  logic [RADDR_W-1:0] ex_rd_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [4:0]         alu_op_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Operand source: EX result beats MEM result beats regfile; x0 is always 0.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data,
        input logic               ex_we,
        input logic [RADDR_W-1:0] ex_waddr,
        input logic [XLEN-1:0]    ex_data,
        input logic               mem_we,
        input logic [RADDR_W-1:0] mem_waddr,
        input logic [XLEN-1:0]    mem_data
    );
        if (rs == '0)                         return '0;
        else if (ex_we && (ex_waddr == rs))   return ex_data;
        else if (mem_we && (mem_waddr == rs)) return mem_data;
        else                                  return rf_data;
    endfunction

    // Instruction fields
    logic [6:0]         opcode_p0;
    logic [2:0]         funct3_p0;
    logic [6:0]         funct7_p0;
    logic [RADDR_W-1:0] rs1_p0, rs2_p0, rd_p0;
    logic signed [11:0]     imm12_p0;
    logic signed [XLEN-1:0] imm_sx_p0;

    assign opcode_p0 = inst_i[6:0];
    assign rd_p0     = inst_i[11:7];
    assign funct3_p0 = inst_i[14:12];
    assign rs1_p0    = inst_i[19:15];
    assign rs2_p0    = inst_i[24:20];
    assign funct7_p0 = inst_i[31:25];
    assign imm12_p0  = inst_i[31:20];
    assign imm_sx_p0 = {{(XLEN-12){imm12_p0[11]}}, imm12_p0};

    // Decode results
    logic       legal_p0, use_rs1_p0, use_rs2_p0, is_itype_p0;
    logic       muldiv_p0, alt_p0, we_p0;
    logic [4:0] alu_op_p0;

    // Classify the instruction and work out which source fields it reads.
    always_comb begin
        legal_p0    = 1'b0;
        use_rs1_p0  = 1'b0;
        use_rs2_p0  = 1'b0;
        is_itype_p0 = 1'b0;
        muldiv_p0   = 1'b0;
        alt_p0      = 1'b0;
        case (opcode_p0)
            OPC_R: begin
                case (funct7_p0)
                    7'b0000000: legal_p0 = 1'b1;
                    7'b0100000: begin
                        legal_p0 = 1'b1;
                        alt_p0   = 1'b1;
                    end
`ifdef ID_MULDIV_EN
                    7'b0000001: begin
                        legal_p0  = 1'b1;
                        muldiv_p0 = 1'b1;
                    end
`endif
                    default: legal_p0 = 1'b0;
                endcase
                use_rs1_p0 = legal_p0;
                use_rs2_p0 = legal_p0;
            end
            OPC_I: begin
                if (funct3_p0 == 3'b001) begin
                    legal_p0 = (inst_i[31:26] == 6'b000000);
                end else if (funct3_p0 == 3'b101) begin
                    if (inst_i[31:26] == 6'b000000) begin
                        legal_p0 = 1'b1;
                    end else if (inst_i[31:26] == 6'b010000) begin
                        legal_p0 = 1'b1;
                        alt_p0   = 1'b1;
                    end
                end else begin
                    legal_p0 = 1'b1;
                end
                use_rs1_p0  = legal_p0;
                is_itype_p0 = legal_p0;
            end
            default: legal_p0 = 1'b0;
        endcase
    end

    assign we_p0     = legal_p0 && (rd_p0 != '0);
    assign alu_op_p0 = legal_p0 ? {muldiv_p0, alt_p0, funct3_p0} : 5'b0;

    // Regfile read ports only light up for a valid instruction that uses the field
    assign reg1_re_o    = in_valid_i && use_rs1_p0;
    assign reg2_re_o    = in_valid_i && use_rs2_p0;
    assign reg1_raddr_o = reg1_re_o ? rs1_p0 : '0;
    assign reg2_raddr_o = reg2_re_o ? rs2_p0 : '0;

    // Operands after forwarding
    logic [XLEN-1:0] fwd1_p0, fwd2_p0, op1_p0, op2_p0;

    assign fwd1_p0 = fwd_sel(rs1_p0, reg1_rdata_i, ex_fwd_we_i, ex_fwd_waddr_i, ex_fwd_data_i,
                             mem_fwd_we_i, mem_fwd_waddr_i, mem_fwd_data_i);
    assign fwd2_p0 = fwd_sel(rs2_p0, reg2_rdata_i, ex_fwd_we_i, ex_fwd_waddr_i, ex_fwd_data_i,
                             mem_fwd_we_i, mem_fwd_waddr_i, mem_fwd_data_i);
    assign op1_p0  = use_rs1_p0 ? fwd1_p0 : '0;
    assign op2_p0  = use_rs2_p0  ? fwd2_p0 :
                     is_itype_p0 ? imm_sx_p0 : '0;

    // Load-use hazard: the loaded value is not forwardable until it leaves EX
    logic hz_p0, accept_p0;

    assign hz_p0 = in_valid_i && ex_is_load_i && (ex_rd_i != '0) &&
                   ((use_rs1_p0 && (rs1_p0 == ex_rd_i)) ||
                    (use_rs2_p0 && (rs2_p0 == ex_rd_i)));

    logic vld_p1;

    assign in_ready_o = (!vld_p1 || out_ready_i) && !hz_p0 && !flush_i;
    assign accept_p0  = in_valid_i && in_ready_o;

    // ---- p0 -> p1 stage boundary ----
    logic [XLEN-1:0]    op1_p1, op2_p1;
    logic [4:0]         alu_op_p1;
    logic               we_p1, illegal_p1;
    logic [RADDR_W-1:0] waddr_p1;
    logic [CNT_W-1:0]   stall_cnt_p1;

    // Handshake to EX: flush kills, accept captures, drain clears, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            op1_p1     <= '0;
            op2_p1     <= '0;
            alu_op_p1  <= '0;
            we_p1      <= 1'b0;
            waddr_p1   <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            op1_p1     <= op1_p0;
            op2_p1     <= op2_p0;
            alu_op_p1  <= alu_op_p0;
            we_p1      <= we_p0;
            waddr_p1   <= rd_p0;
            illegal_p1 <= !legal_p0;
        end else if (vld_p1 && out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    // Count every cycle spent in a load-use hazard; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (hz_p0) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign out_valid_o = vld_p1;
    assign op1_o       = op1_p1;
    assign op2_o       = op2_p1;
    assign alu_op_o    = alu_op_p1;
    assign reg_we_o    = we_p1;
    assign reg_waddr_o = waddr_p1;
    assign illegal_o   = illegal_p1;
    assign stall_cnt_o = stall_cnt_p1;

endmodule

// File: tb/tb_id_stage_rim.sv
// Testbench for id_stage_rim: directed steps followed by random traffic,
// checked against a reference model of the decode stage kept in the bench.
module tb_id_stage_rim;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 4;

    logic            clk, rst_n;
    logic            in_valid, in_ready;
    logic [ILEN-1:0] inst;
    logic [RW-1:0]   reg1_raddr, reg2_raddr;
    logic            reg1_re, reg2_re;
    logic [XLEN-1:0] reg1_rdata, reg2_rdata;
    logic            ex_we, mem_we;
    logic [RW-1:0]   ex_waddr, mem_waddr;
    logic [XLEN-1:0] ex_data, mem_data;
    logic            ex_is_load;
    logic [RW-1:0]   ex_rd;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] op1, op2;
    logic [4:0]      alu_op;
    logic            reg_we, illegal;
    logic [RW-1:0]   reg_waddr;
    logic [CW-1:0]   stall_cnt;

    logic [XLEN-1:0] rf [32];
    assign reg1_rdata = rf[reg1_raddr];
    assign reg2_rdata = rf[reg2_raddr];

    id_stage_rim #(.XLEN(XLEN), .ILEN(ILEN), .RADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
        .reg1_raddr_o(reg1_raddr), .reg2_raddr_o(reg2_raddr),
        .reg1_re_o(reg1_re), .reg2_re_o(reg2_re),
        .reg1_rdata_i(reg1_rdata), .reg2_rdata_i(reg2_rdata),
        .ex_fwd_we_i(ex_we), .ex_fwd_waddr_i(ex_waddr), .ex_fwd_data_i(ex_data),
        .mem_fwd_we_i(mem_we), .mem_fwd_waddr_i(mem_waddr), .mem_fwd_data_i(mem_data),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .op1_o(op1), .op2_o(op2), .alu_op_o(alu_op),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .illegal_o(illegal),
        .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state of the EX-facing payload
    logic            m_valid, m_we, m_ill;
    logic [XLEN-1:0] m_op1, m_op2;
    logic [4:0]      m_aop;
    logic [RW-1:0]   m_waddr;
    int              m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_ill = 1'b0;
        m_op1 = '0; m_op2 = '0; m_aop = '0; m_waddr = '0; m_cnt = 0;
    endtask

    // What the instruction means: legality, which sources it reads, ALU op, immediate operand
    function automatic void ref_dec(input logic [31:0] in, output logic legal,
                                    output logic u1, output logic u2,
                                    output logic [4:0] aop, output logic [63:0] imm_op);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = in[6:0]; f3 = in[14:12]; f7 = in[31:25];
        legal = 1'b0; u1 = 1'b0; u2 = 1'b0; aop = '0; imm_op = '0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 || f7 == 7'h20) begin
                legal = 1'b1;
                aop = {1'b0, f7 == 7'h20, f3};
            end
`ifdef ID_MULDIV_EN
            else if (f7 == 7'h01) begin
                legal = 1'b1;
                aop = {2'b10, f3};
            end
`endif
            u1 = legal; u2 = legal;
        end else if (opc == 7'h13) begin
            if (f3 == 3'b001)      legal = (in[31:26] == 6'd0);
            else if (f3 == 3'b101) legal = (in[31:26] == 6'd0) || (in[31:26] == 6'b010000);
            else                   legal = 1'b1;
            if (legal) begin
                u1 = 1'b1;
                aop = {1'b0, (f3 == 3'b101) && in[30], f3};
                imm_op = {{52{in[31]}}, in[31:20]};
            end
        end
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 64'd0;
        if (ex_we && ex_waddr == rs) return ex_data;
        if (mem_we && mem_waddr == rs) return mem_data;
        return rf[rs];
    endfunction

    task automatic check_regs();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("op1", op1, m_op1);
        chk("op2", op2, m_op2);
        chk("alu_op", 64'(alu_op), 64'(m_aop));
        chk("reg_we", 64'(reg_we), 64'(m_we));
        chk("reg_waddr", 64'(reg_waddr), 64'(m_waddr));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // One clock: inputs already driven just after a falling edge
    task automatic cycle();
        logic legal, u1, u2, hz, rdy;
        logic [4:0] aop, rs1, rs2, rd;
        logic [63:0] immop, e1, e2;
        ref_dec(inst, legal, u1, u2, aop, immop);
        rs1 = inst[19:15]; rs2 = inst[24:20]; rd = inst[11:7];
        hz  = in_valid && ex_is_load && ex_rd != 0 &&
              ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
        rdy = (!m_valid || out_ready) && !hz && !flush;
        #1;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("reg1_re", 64'(reg1_re), 64'(in_valid && u1));
        chk("reg2_re", 64'(reg2_re), 64'(in_valid && u2));
        chk("reg1_raddr", 64'(reg1_raddr), (in_valid && u1) ? 64'(rs1) : 64'd0);
        chk("reg2_raddr", 64'(reg2_raddr), (in_valid && u2) ? 64'(rs2) : 64'd0);
        e1 = u1 ? ref_fwd(rs1) : 64'd0;
        e2 = u2 ? ref_fwd(rs2) : immop;
        if (flush) m_valid = 1'b0;
        else if (in_valid && rdy) begin
            m_valid = 1'b1; m_op1 = e1; m_op2 = e2; m_aop = aop;
            m_we = legal && rd != 0; m_waddr = rd; m_ill = !legal;
        end else if (m_valid && out_ready) m_valid = 1'b0;
        if (hz && m_cnt < (1 << CW) - 1) m_cnt++;
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] a, b, d;
        logic [2:0] f3;
        logic [5:0] up;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        case ($urandom_range(0, 5))
            0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, b, a, f3, d, 7'h33};
            1: return {7'h01, b, a, f3, d, 7'h33};
            2: return {7'($urandom), b, a, f3, d, 7'h33};
            3: return {12'($urandom), a, f3, d, 7'h13};
            4: begin
                up = ($urandom_range(0, 2) == 0) ? 6'd0 :
                     ($urandom_range(0, 1) == 0) ? 6'b010000 : 6'($urandom);
                return {up, 6'($urandom), a, ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001, d, 7'h13};
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b1; flush = 1'b0;
        ex_we = 1'b0; ex_waddr = '0; ex_data = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_data = '0;
        ex_is_load = 1'b0; ex_rd = '0;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[0] = 64'hDEAD_BEEF_0000_0000;
        rf[1] = 64'h11;
        rf[2] = 64'h22;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        rst_n = 1'b1;

        // Basic R/I decode
        in_valid = 1'b1; inst = 32'h002081B3; cycle();
        inst = 32'h402081B3; cycle();
        inst = 32'hFFF00293; cycle();

        // Forwarding priority and x0 immunity
        inst = 32'h002081B3;
        ex_we = 1'b1; ex_waddr = 5'd1; ex_data = 64'h55;
        mem_we = 1'b1; mem_waddr = 5'd1; mem_data = 64'h66;
        cycle();
        ex_we = 1'b0; cycle();
        ex_we = 1'b1; ex_waddr = 5'd0; mem_waddr = 5'd0; inst = 32'hFFF00293; cycle();
        ex_we = 1'b0; mem_we = 1'b0;

        // Load-use hazard for one cycle, then accepted
        inst = 32'h002081B3; ex_is_load = 1'b1; ex_rd = 5'd1; cycle();
        ex_is_load = 1'b0; cycle();

        // Backpressure holds the payload, then flush kills it
        out_ready = 1'b0; inst = 32'h402081B3; cycle();
        inst = 32'h00500093;
        repeat (3) cycle();
        flush = 1'b1; cycle();
        flush = 1'b0; out_ready = 1'b1;

        // M-extension encoding and an illegal opcode
        inst = 32'h022081B3; cycle();
        inst = 32'h0000007F; cycle();
        inst = 32'h4010D093; cycle();
        inst = 32'h4010908F; cycle();

        // Hold a hazard long enough to saturate the counter
        ex_is_load = 1'b1; ex_rd = 5'd2; inst = 32'h002081B3;
        repeat (18) cycle();

        // Asynchronous reset in the middle of the stall
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1; ex_is_load = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            inst       = rand_inst();
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_we      = $urandom_range(0, 1) != 0;
            ex_waddr   = 5'($urandom_range(0, 7));
            ex_data    = {$urandom, $urandom};
            mem_we     = $urandom_range(0, 1) != 0;
            mem_waddr  = 5'($urandom_range(0, 7));
            mem_data   = {$urandom, $urandom};
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            rf[$urandom_range(1, 31)] = {$urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage_rim.md
Name: id_stage_rim

Overview:
- Registered, parametrised decode stage for the integer pipeline.
- Covers R-type and I-type ALU instructions, with optional M-extension.
- Combinational regfile read, operand forwarding from EX/MEM, load-use hazard stall, valid/ready handshake to EX, flush support, saturating stall counter.
- Sits between IF and EX.

Parameters:
- XLEN, 64, operand/register data width (matches `RDATA_WIDTH).
- ILEN, 32, instruction width (matches `DATA_WIDTH).
- RADDR_W, 5, register address width (matches `RADDR_WIDTH).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  IF holds a valid instruction.
- in_ready_o  out  1  stage accepts the instruction this cycle.
- inst_i  in  ILEN  instruction.
- reg1_raddr_o / reg2_raddr_o  out  RADDR_W  regfile read addresses (combinational).
- reg1_re_o / reg2_re_o  out  1  regfile read enables (combinational).
- reg1_rdata_i / reg2_rdata_i  in  XLEN  regfile read data (same cycle).
- ex_fwd_we_i, ex_fwd_waddr_i[RADDR_W], ex_fwd_data_i[XLEN]  in  EX-stage result for forwarding.
- mem_fwd_we_i, mem_fwd_waddr_i[RADDR_W], mem_fwd_data_i[XLEN]  in  MEM-stage result for forwarding.
- ex_is_load_i  in  1  instruction in EX is a load.
- ex_rd_i  in  RADDR_W  destination register of that load.
- flush_i  in  1  kill the stage contents.
- out_valid_o  out  1  EX payload valid.
- out_ready_i  in  1  EX accepts the payload.
- op1_o, op2_o  out  XLEN  operands (registered).
- alu_op_o  out  5  {muldiv, alt, funct3} (registered).
- reg_we_o  out  1  registered write enable.
- reg_waddr_o  out  RADDR_W  registered write address.
- illegal_o  out  1  registered illegal-instruction flag.
- stall_cnt_o  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Reset (async, rst_n=0): out_valid_o=0, op1_o=op2_o=0, alu_op_o=0, reg_we_o=0, reg_waddr_o=0, illegal_o=0, stall_cnt_o=0.
- Decode, combinational from inst_i:
  - R: opcode 0110011, funct7 0000000 or 0100000 (alt=inst[30]). Uses rs1+rs2; op2=rs2 value.
  - I: opcode 0010011. Uses rs1 only; op2 = sign-extended inst[31:20] to XLEN.
  - I-type shifts (funct3 001/101): require inst[31:26] equal to 000000, or 010000 for funct3=101 (alt=1). Otherwise illegal.
  - Non-shift I-type: alt=0.
  - Any other opcode or funct7: illegal=1, we=0, re=0, operands 0.
  - rd=0 forces we=0; still legal.
- Read ports: raddr = rs1/rs2 and re=1 only when in_valid_i and the field is used. Otherwise raddr=0, re=0.
- Forwarding per operand, in priority order:
  1. EX match (we && waddr==rs && rs!=0)
  2. MEM match
  3. regfile data
  - x0 always reads 0.
- Hazard: hz = in_valid_i && ex_is_load_i && ex_rd_i!=0 && (rs1 used && rs1==ex_rd_i || rs2 used && rs2==ex_rd_i).
- in_ready_o = (!out_valid_o || out_ready_i) && !hz && !flush_i.
- Accept (in_valid_i && in_ready_o): capture all registered outputs next edge; out_valid_o=1. Latency 1 cycle.
- Drain (out_valid_o && out_ready_i, no accept): out_valid_o=0. Payload is held otherwise.
- Stall with hz and free output: bubble, out_valid_o=0. EX advances, next cycle re-evaluates.
- flush_i: highest priority. Next edge out_valid_o=0, no capture; payload registers keep old values.
- stall_cnt_o: +1 on every cycle hz=1, saturates at all-ones, never wraps. Flush does not clear it.
- Illegal instruction: still handshaken through with illegal_o=1, reg_we_o=0.

Optional Feature:
- Macro ID_MULDIV_EN.
- Defined: opcode 0110011 with funct7 0000001 is legal; alu_op_o[4]=1, alt=0, we per rd.
- Undefined: same encoding is illegal (illegal_o=1, we=0); alu_op_o[4] is always 0.

Test Plan:
- 0x002081B3 (add x3,x1,x2), rdata1=0x11, rdata2=0x22, no fwd -> next cycle out_valid=1, op1=0x11, op2=0x22, alu_op=00000, we=1, waddr=3.
- 0x402081B3 (sub) -> alu_op=01000. 0xFFF00293 (addi x5,x0,-1) -> op1=0, op2=all ones, reg2_re=0, waddr=5.
- add x3,x1,x2 with ex_fwd x1=0x55 and mem_fwd x1=0x66, rdata1=0x11 -> op1=0x55. With ex_fwd_we=0 -> op1=0x66. With forward to x0 -> ignored.
- ex_is_load=1, ex_rd=1, add x3,x1,x2 for one cycle -> in_ready=0, out_valid=0 that cycle, stall_cnt=1. Next cycle (load cleared) -> accepted.
- out_ready=0 for 3 cycles with a pending payload -> payload stable, in_ready=0. flush_i pulse -> out_valid=0 next edge.
- 0x022081B3 (mul): with ID_MULDIV_EN -> alu_op=10000, illegal=0. Without it -> illegal=1, we=0. Reset asserted mid-stall -> all outputs 0 immediately.
